// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream (length, payload, checksum)
// over a valid/ready handshake and writes the payload into the CPU's
// instruction memory. The CPU is held in reset until an image with a good
// checksum has been written.
module prog_loader #(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [8:0]        byte_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    logic [2:0]        state_q,      state_d;
    logic [7:0]        len_q,        len_d;
    logic [7:0]        sum_q,        sum_d;
    logic [8:0]        byte_count_q, byte_count_d;
    logic [ADDR_W-1:0] offset_q,     offset_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [7:0]        imem_wdata_q, imem_wdata_d;
    logic              cpu_hold_q,   cpu_hold_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;

    logic              in_ready_s;
    logic              accept_s;
    logic [7:0]        sum_next_s;
    logic [8:0]        count_next_s;
    logic [8:0]        target_s;

    // Handshake readiness depends on state only, never on in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_LEN, ST_DATA, ST_CSUM: in_ready_s = 1'b1;
            default:                  in_ready_s = 1'b0;
        endcase
    end

    // Datapath helpers: running checksum, next count and payload length
    // (a length byte of zero stands for a full 256-byte image).
    always_comb begin
        accept_s     = in_valid & in_ready_s;
        sum_next_s   = sum_q + in_data;
        count_next_s = byte_count_q + 9'd1;
        if (len_q == 8'd0) begin
            target_s = 9'd256;
        end else begin
            target_s = {1'b0, len_q};
        end
    end

    // Next-state and next-value logic for the load sequence.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        sum_d        = sum_q;
        byte_count_d = byte_count_q;
        offset_d     = offset_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d      = ST_LEN;
                    byte_count_d = 9'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    len_d        = in_data;
                    sum_d        = 8'd0;
                    byte_count_d = 9'd0;
                    offset_d     = {ADDR_W{1'b0}};
                    state_d      = ST_DATA;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    sum_d        = sum_next_s;
                    byte_count_d = count_next_s;
                    offset_d     = offset_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    imem_we_d    = 1'b1;
                    imem_addr_d  = BASE_ADDR + offset_q;
                    imem_wdata_d = in_data;
                    if (count_next_s == target_s) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (sum_next_s == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_comb begin
        cpu_hold_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        case (state_d)
            ST_LEN, ST_DATA, ST_CSUM: busy_d = 1'b1;
            default:                  busy_d = 1'b0;
        endcase
    end

    // State and output registers; reset also kills any pending write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= 8'd0;
            sum_q        <= 8'd0;
            byte_count_q <= 9'd0;
            offset_q     <= {ADDR_W{1'b0}};
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= 8'd0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            byte_count_q <= byte_count_d;
            offset_q     <= offset_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Two instances share all inputs: one
// with the default base address and one with base F0 for the wrap case.
// Expected writes are queued as payload bytes are driven and popped when
// each instance raises its write strobe.
module tb_prog_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready,   in_ready_w;
    logic       imem_we,    imem_we_w;
    logic [7:0] imem_addr,  imem_addr_w;
    logic [7:0] imem_wdata, imem_wdata_w;
    logic       cpu_hold,   cpu_hold_w;
    logic       busy,       busy_w;
    logic       done,       done_w;
    logic       err,        err_w;
    logic [8:0] byte_count, byte_count_w;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] expw_q[$];
    logic [7:0]  mem  [256];
    logic [7:0]  memw [256];
    int          wr_idx;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err(err), .byte_count(byte_count)
    );

    prog_loader #(.ADDR_W(8), .BASE_ADDR(8'hF0)) dut_w (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready_w), .imem_we(imem_we_w),
        .imem_addr(imem_addr_w), .imem_wdata(imem_wdata_w), .cpu_hold(cpu_hold_w),
        .busy(busy_w), .done(done_w), .err(err_w), .byte_count(byte_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitors: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [15:0] e;
        if (imem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write_base00: got addr=%h data=%h, expected addr=%h data=%h",
                             imem_addr, imem_wdata, e[15:8], e[7:0]);
                end
            end
            mem[imem_addr] = imem_wdata;
        end
        if (imem_we_w === 1'b1) begin
            n_checks++;
            if (expw_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_w_unexpected: got addr=%h data=%h, expected no write", imem_addr_w, imem_wdata_w);
            end else begin
                e = expw_q.pop_front();
                if ({imem_addr_w, imem_wdata_w} !== e) begin
                    n_fail++;
                    $display("FAIL write_baseF0: got addr=%h data=%h, expected addr=%h data=%h",
                             imem_addr_w, imem_wdata_w, e[15:8], e[7:0]);
                end
            end
            memw[imem_addr_w] = imem_wdata_w;
        end
    end

    task automatic start_load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wr_idx = 0;
        n_checks++;
        if ({busy, done, err, cpu_hold, busy_w} !== 5'b10011) begin
            n_fail++;
            $display("FAIL start_flags: got busy=%b done=%b err=%b hold=%b busy_w=%b, expected 1 0 0 1 1",
                     busy, done, err, cpu_hold, busy_w);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit is_data);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (is_data) begin
            exp_q.push_back({8'(8'h00 + wr_idx), b});
            expw_q.push_back({8'(8'hF0 + wr_idx), b});
            wr_idx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (imem_we !== is_data) begin
            n_fail++;
            $display("FAIL write_timing: imem_we=%b after accepting %h, expected %b", imem_we, b, is_data);
        end
    endtask

    task automatic check_end(input logic exp_done, input logic [8:0] exp_cnt);
        n_checks++;
        if ({done, err, cpu_hold, busy, in_ready} !== {exp_done, ~exp_done, ~exp_done, 1'b0, 1'b0}
            || byte_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL end_state: got done=%b err=%b hold=%b busy=%b rdy=%b cnt=%0d, expected done=%b err=%b hold=%b busy=0 rdy=0 cnt=%0d",
                     done, err, cpu_hold, busy, in_ready, byte_count, exp_done, ~exp_done, ~exp_done, exp_cnt);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0 || expw_q.size() != 0) begin
            n_fail++;
            $display("FAIL writes_missing: %0d/%0d pending, expected 0/0", exp_q.size(), expw_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({cpu_hold, in_ready, imem_we, busy, done, err} !== 6'b100000
            || imem_addr !== 8'h00 || imem_wdata !== 8'h00 || byte_count !== 9'd0
            || imem_addr_w !== 8'hF0) begin
            n_fail++;
            $display("FAIL reset_state: hold=%b rdy=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h cnt=%0d addr_w=%h, expected 1 0 0 0 0 0 00 00 0 F0",
                     cpu_hold, in_ready, imem_we, busy, done, err, imem_addr, imem_wdata, byte_count, imem_addr_w);
        end
    endtask

    task automatic test_nominal();
        start_load();
        send(8'h03, 1'b0);
        send(8'h00, 1'b1);
        send(8'h2F, 1'b1);
        send(8'h01, 1'b1);
        n_checks++;
        if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_csum_hold: hold=%b busy=%b before checksum, expected 1 1", cpu_hold, busy);
        end
        send(8'hD0, 1'b0);
        check_end(1'b1, 9'd3);
    endtask

    task automatic test_bad_csum();
        start_load();
        send(8'h03, 1'b0);
        send(8'h00, 1'b1);
        send(8'h2F, 1'b1);
        send(8'h01, 1'b1);
        send(8'hD1, 1'b0);
        check_end(1'b0, 9'd3);
    endtask

    task automatic test_len_zero();
        start_load();
        send(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) send(8'h01, 1'b1);
        send(8'h00, 1'b0);
        check_end(1'b1, 9'd256);
    endtask

    task automatic test_stall_wrap();
        logic [7:0] sum;
        logic [7:0] b;
        int         g;
        sum = 8'h00;
        start_load();
        send(8'h20, 1'b0);
        for (int i = 0; i < 32; i++) begin
            b = 8'($urandom_range(0, 255));
            sum = sum + b;
            send(b, 1'b1);
            g = $urandom_range(1, 5);
            for (int k = 0; k < g; k++) begin
                @(posedge clk); #1;
                if (i < 31) begin
                    n_checks++;
                    if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_we_w !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall: rdy=%b we=%b we_w=%b during stall, expected 1 0 0", in_ready, imem_we, imem_we_w);
                    end
                end
            end
        end
        send(8'(8'h00 - sum), 1'b0);
        n_checks++;
        if (done_w !== 1'b1 || cpu_hold_w !== 1'b0 || byte_count_w !== 9'd32) begin
            n_fail++;
            $display("FAIL wrap_done: done_w=%b hold_w=%b cnt_w=%0d, expected 1 0 32", done_w, cpu_hold_w, byte_count_w);
        end
        check_end(1'b1, 9'd32);
    endtask

    task automatic test_robust();
        start_load();
        send(8'h03, 1'b0);
        send(8'h5A, 1'b1);
        send(8'hC3, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || byte_count !== 9'd2 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: busy=%b rdy=%b cnt=%0d done=%b, expected 1 1 2 0", busy, in_ready, byte_count, done);
        end
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({busy, cpu_hold, in_ready, imem_we, done, err} !== 6'b010000 || byte_count !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_midload: busy=%b hold=%b rdy=%b we=%b done=%b err=%b cnt=%0d, expected 0 1 0 0 0 0 0",
                     busy, cpu_hold, in_ready, imem_we, done, err, byte_count);
        end
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (mem[0] !== 8'h5A || mem[1] !== 8'hC3 || memw[8'hF0] !== 8'h5A || memw[8'hF1] !== 8'hC3) begin
            n_fail++;
            $display("FAIL retained: mem[00]=%h mem[01]=%h memw[F0]=%h memw[F1]=%h, expected 5A C3 5A C3",
                     mem[0], mem[1], memw[8'hF0], memw[8'hF1]);
        end
        test_nominal();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        wr_idx   = 0;
        test_reset();
        test_nominal();
        test_bad_csum();
        test_len_zero();
        test_stall_wrap();
        test_robust();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
